// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
//   Bundles the request/response handshake and the ALU control outputs of the
//   ALU op sequencer.
//   master: requester side (drives op_valid, opcode, res_ready)
//   slave : sequencer side (drives op_ready, alu_op, z_load, busy,
//           res_valid, res_err, op_count)
//   CNT_W : width of op_count; must match the sequencer's CNT_W.
interface alu_op_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             op_valid;
  logic             op_ready;
  logic [3:0]       opcode;
  logic [12:0]      alu_op;
  logic             z_load;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic             res_err;
  logic [CNT_W-1:0] op_count;

  modport master (
    output op_valid, opcode, res_ready,
    input  op_ready, alu_op, z_load, busy, res_valid, res_err, op_count
  );

  modport slave (
    input  op_valid, opcode, res_ready,
    output op_ready, alu_op, z_load, busy, res_valid, res_err, op_count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Multi-cycle controller that sequences the datapath ALU. One opcode is
//   accepted per transaction, the matching one-hot ALU line is held for the
//   op latency plus a capture cycle in which z_load strobes the Z register,
//   then a completion response is returned.
// Ports
//   clk  : system clock, rising edge
//   clr  : asynchronous active-high reset
//   bus  : alu_op_sequencer_if.slave
//          op_valid/op_ready/opcode      request handshake
//          alu_op[12:0]                  one-hot ALU op lines (bit n = opcode n)
//          z_load                        one-cycle Z register load strobe
//          busy                          high outside IDLE
//          res_valid/res_ready/res_err   completion handshake
//          op_count[CNT_W-1:0]           completed legal ops, wrapping
// Configuration
//   SEQ_ILLEGAL_TRAP_EN : when defined, opcodes 13-15 skip execution and
//   complete immediately with res_err=1. When undefined they execute as NOT.
module alu_op_sequencer #(
  parameter int MUL_LAT = 1,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               clr,
  alu_op_sequencer_if.slave  bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);

`ifdef SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [3:0] OP_MUL = 4'd4;
  localparam logic [3:0] OP_DIV = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd11;
  localparam logic [3:0] OP_MAX = 4'd12;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CAPT,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q;

  logic             illegal;
  logic [3:0]       eff_op;
  logic [LAT_W-1:0] lat_load;

  // Illegal opcodes are remapped to NOT unless trapping; the latched copy is
  // therefore always a legal op index and alu_op stays one-hot.
  always_comb begin
    illegal = (bus.opcode > OP_MAX);
    eff_op  = (illegal && !TRAP) ? OP_NOT : bus.opcode;
    if (eff_op == OP_MUL) begin
      lat_load = LAT_W'(MUL_LAT - 1);
    end else if (eff_op == OP_DIV) begin
      lat_load = LAT_W'(DIV_LAT - 1);
    end else begin
      lat_load = '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    lat_d         = lat_q;
    err_d         = err_q;
    bus.op_ready  = 1'b0;
    bus.alu_op    = '0;
    bus.z_load    = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_err   = 1'b0;
    bus.busy      = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        bus.op_ready = 1'b1;
        if (bus.op_valid) begin
          op_d  = eff_op;
          lat_d = lat_load;
          err_d = TRAP && illegal;
          state_d = (TRAP && illegal) ? RESP : EXEC;
        end
      end
      EXEC: begin
        bus.alu_op = 13'(1) << op_q;
        if (lat_q == '0) begin
          state_d = CAPT;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      CAPT: begin
        // alu_op stays asserted so the ALU output is stable while Z loads.
        bus.alu_op = 13'(1) << op_q;
        bus.z_load = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        bus.res_valid = 1'b1;
        bus.res_err   = err_q;
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      op_q    <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
      if (state_q == CAPT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.op_count = cnt_q;

endmodule
